// File: rtl/mult_bus_master.sv
// Bus-side controller that sequences operand loads, start, wait and product readback for one multiplier.
// Optional WAIT-state timeout is enabled by defining MBM_TIMEOUT_EN.
module mult_bus_master #(
  parameter int unsigned n       = 8,
  parameter int unsigned TIMEOUT = 4 * n
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] product,
  output logic           err,
  output logic           start,
  output logic [1:0]     func,
  output logic           oe,
  input  logic           mready,
  inout  wire  [n-1:0]   data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_M, S_LOAD_Q, S_START, S_WAIT, S_READ_LO, S_READ_HI, S_DONE
  } state_t;

  localparam logic [1:0] F_LOAD_M  = 2'b00;
  localparam logic [1:0] F_LOAD_Q  = 2'b01;
  localparam logic [1:0] F_READ_LO = 2'b10;
  localparam logic [1:0] F_READ_HI = 2'b11;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_guard;
  logic         r_drv_en;
  logic [n-1:0] r_drv_data;
  logic [n-1:0] r_b;
  logic         w_timeout;
  logic         w_accept;

  logic [1:0]   w_func_nxt;
  logic         w_oe_nxt;
  logic         w_start_nxt;
  logic         w_in_ready_nxt;
  logic         w_out_valid_nxt;
  logic         w_drv_en_nxt;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign data     = r_drv_en ? r_drv_data : {n{1'bz}};

`ifdef MBM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wcnt;
  logic             r_err;

  // r_wcnt is the 1-based index of the current WAIT cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wcnt <= CNT_W'(1);
    end else if (r_wcnt != CNT_W'(TIMEOUT)) begin
      r_wcnt <= r_wcnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wcnt == CNT_W'(TIMEOUT)) && !mready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_err <= 1'b0;
    else if (w_accept)  r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are decoded from the next state so they are registered and aligned with it
  always_comb begin
    w_state_nxt     = r_state;
    w_func_nxt      = F_READ_LO;
    w_oe_nxt        = 1'b0;
    w_start_nxt     = 1'b0;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_drv_en_nxt    = 1'b0;

    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_LOAD_M;
      S_LOAD_M:  w_state_nxt = S_LOAD_Q;
      S_LOAD_Q:  w_state_nxt = S_START;
      S_START:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_timeout)              w_state_nxt = S_DONE;
        else if (!r_guard && mready) w_state_nxt = S_READ_LO;
      end
      S_READ_LO: w_state_nxt = S_READ_HI;
      S_READ_HI: w_state_nxt = S_DONE;
      S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_IDLE:    w_in_ready_nxt = 1'b1;
      S_LOAD_M: begin
        w_func_nxt   = F_LOAD_M;
        w_drv_en_nxt = 1'b1;
      end
      S_LOAD_Q: begin
        w_func_nxt   = F_LOAD_Q;
        w_drv_en_nxt = 1'b1;
      end
      S_START:   w_start_nxt = 1'b1;
      S_READ_LO: w_oe_nxt = 1'b1;
      S_READ_HI: begin
        w_func_nxt = F_READ_HI;
        w_oe_nxt   = 1'b1;
      end
      S_DONE:    w_out_valid_nxt = 1'b1;
      default:   w_in_ready_nxt = 1'b0;
    endcase
  end

  // Guard flag marks the first WAIT cycle, when mready may still be stale
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_guard <= 1'b0;
    else       r_guard <= (r_state == S_START);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      start      <= 1'b0;
      func       <= F_READ_LO;
      oe         <= 1'b0;
      r_drv_en   <= 1'b0;
      r_drv_data <= '0;
      r_b        <= '0;
      product    <= '0;
    end else begin
      in_ready  <= w_in_ready_nxt;
      out_valid <= w_out_valid_nxt;
      start     <= w_start_nxt;
      func      <= w_func_nxt;
      oe        <= w_oe_nxt;
      r_drv_en  <= w_drv_en_nxt;
      if (w_accept) begin
        r_drv_data <= a;
        r_b        <= b;
      end else if (r_state == S_LOAD_M) begin
        r_drv_data <= r_b;
      end
      if (w_timeout)                   product          <= '0;
      else if (r_state == S_READ_LO)   product[n-1:0]   <= data;
      else if (r_state == S_READ_HI)   product[2*n-1:n] <= data;
    end
  end

endmodule

// File: tb/tb_mult_bus_master.sv
// Directed self-checking bench for mult_bus_master with a small bus-level multiplier model.
module tb_mult_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        err;
  logic        start;
  logic [1:0]  func;
  logic        oe;
  logic        mready = 1'b1;
  wire  [7:0]  data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_m = '0;
  logic [7:0]  m_q = '0;
  logic [15:0] m_p = '0;

  mult_bus_master #(.n(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .err(err), .start(start), .func(func), .oe(oe), .mready(mready), .data(data)
  );

  always #5 clock = ~clock;

  // Bus-level multiplier: latches operands from the bus, drives result halves when oe=1
  always @(posedge clock) begin
    if (!oe && func == 2'b00) m_m <= data;
    if (!oe && func == 2'b01) m_q <= data;
    if (start) m_p <= 16'(m_m) * 16'(m_q);
  end
  assign data = oe ? ((func == 2'b11) ? m_p[15:8] : m_p[7:0]) : 8'bz;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present an operand pair and return in cycle 1 (LOAD_M)
  task automatic start_txn(input logic [7:0] ta, input logic [7:0] tb);
    int k = 0;
    while (!in_ready && k < 100) begin step(); k++; end
    a = ta; b = tb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin step(); cyc++; end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (product !== 16'h0)   begin n_fail++; $display("FAIL reset_product: got %h want 0", product); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (start !== 1'b0)      begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_checks++; if (func !== 2'b10)      begin n_fail++; $display("FAIL reset_func: got %b want 10", func); end
    n_checks++; if (oe !== 1'b0)         begin n_fail++; $display("FAIL reset_oe: got %b want 0", oe); end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [1:0] ef [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    logic       es [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    mready = 1'b1; out_ready = 1'b1;
    start_txn(8'd13, 8'd11);
    for (int c = 0; c < 7; c++) begin
      n_checks++; if (func !== ef[c])  begin n_fail++; $display("FAIL basic_func c%0d: got %b want %b", c + 1, func, ef[c]); end
      n_checks++; if (start !== es[c]) begin n_fail++; $display("FAIL basic_start c%0d: got %b want %b", c + 1, start, es[c]); end
      n_checks++; if (oe !== eo[c])    begin n_fail++; $display("FAIL basic_oe c%0d: got %b want %b", c + 1, oe, eo[c]); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid c%0d: got %b want 0", c + 1, out_valid); end
      if (c == 0) begin
        n_checks++; if (data !== 8'd13) begin n_fail++; $display("FAIL basic_data_m: got %0d want 13", data); end
      end
      if (c == 1) begin
        n_checks++; if (data !== 8'd11) begin n_fail++; $display("FAIL basic_data_q: got %0d want 11", data); end
      end
      step();
    end
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    n_checks++; if (product !== 16'd143)  begin n_fail++; $display("FAIL basic_product: got %0d want 143", product); end
    n_checks++; if (err !== 1'b0)         begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_full_range();
    int cyc;
    mready = 1'b1; out_ready = 1'b1;
    start_txn(8'hFF, 8'hFF);
    wait_valid(cyc);
    n_checks++; if (cyc != 7)              begin n_fail++; $display("FAIL full_latency: got %0d want 7", cyc); end
    n_checks++; if (product !== 16'hFE01)  begin n_fail++; $display("FAIL full_ff_product: got %h want fe01", product); end
    step();
    start_txn(8'h00, 8'hAA);
    wait_valid(cyc);
    n_checks++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL full_zero_valid: got %b want 1", out_valid); end
    n_checks++; if (product !== 16'h0000)  begin n_fail++; $display("FAIL full_zero_product: got %h want 0000", product); end
    step();
  endtask

  task automatic test_slow();
    int cyc;
    mready = 1'b1; out_ready = 1'b1;
    start_txn(8'd200, 8'd3);
    step(); step();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL slow_start: got %b want 1", start); end
    step();
    mready = 1'b0;
    for (int c = 4; c <= 20; c++) begin
      n_checks++;
      if (oe !== 1'b0 || func !== 2'b10 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL slow_wait c%0d: oe %b func %b out_valid %b want 0 10 0", c, oe, func, out_valid);
      end
      step();
    end
    mready = 1'b1;
    n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL slow_wait_last: oe %b want 0", oe); end
    step();
    n_checks++; if (oe !== 1'b1 || func !== 2'b10) begin n_fail++; $display("FAIL slow_read_lo: oe %b func %b want 1 10", oe, func); end
    step();
    n_checks++; if (oe !== 1'b1 || func !== 2'b11) begin n_fail++; $display("FAIL slow_read_hi: oe %b func %b want 1 11", oe, func); end
    step();
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL slow_valid_c24: got %b want 1", out_valid); end
    n_checks++; if (product !== 16'd600)  begin n_fail++; $display("FAIL slow_product: got %0d want 600", product); end
    wait_valid(cyc);
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    mready = 1'b1; out_ready = 1'b0;
    start_txn(8'd25, 8'd9);
    wait_valid(cyc);
    n_checks++; if (product !== 16'd225) begin n_fail++; $display("FAIL bp_product: got %0d want 225", product); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || product !== 16'd225 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold %0d: out_valid %b product %0d in_ready %b want 1 225 0", i, out_valid, product, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    n_checks++; if (product !== 16'd225) begin n_fail++; $display("FAIL bp_product_hold: got %0d want 225", product); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mready = 1'b0; out_ready = 1'b1;
    start_txn(8'd7, 8'd9);
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (start !== 1'b0 || oe !== 1'b0 || func !== 2'b10) begin n_fail++; $display("FAIL rmid_bus: start %b oe %b func %b want 0 0 10", start, oe, func); end
    n_checks++; if (product !== 16'h0)   begin n_fail++; $display("FAIL rmid_product: got %0d want 0", product); end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_hs: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    step();
    reset = 1'b0;
    mready = 1'b1;
    step();
    start_txn(8'd3, 8'd5);
    wait_valid(cyc);
    n_checks++; if (cyc != 7 || product !== 16'd15) begin n_fail++; $display("FAIL rmid_after: latency %0d product %0d want 7 15", cyc, product); end
    step();
  endtask

`ifdef MBM_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    mready = 1'b0; out_ready = 1'b1;
    start_txn(8'd6, 8'd7);
    wait_valid(cyc);
    n_checks++; if (cyc != 35)          begin n_fail++; $display("FAIL to_latency: got %0d want 35", cyc); end
    n_checks++; if (err !== 1'b1)       begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    n_checks++; if (product !== 16'h0)  begin n_fail++; $display("FAIL to_product: got %0d want 0", product); end
    step();
    mready = 1'b1;
    start_txn(8'd6, 8'd7);
    wait_valid(cyc);
    n_checks++; if (err !== 1'b0 || product !== 16'd42) begin n_fail++; $display("FAIL to_recover: err %b product %0d want 0 42", err, product); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_slow();
    test_backpressure();
    test_reset_mid();
`ifdef MBM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
